core_csr_unit_counter_port: RTL and testbench
=============================================

// Module: core_csr_unit_counter_port
// PURPOSE
//  CSR-side responder for one 64-bit event counter (mcycle/minstret style) on a 32-bit CSR bus.
//  Owns the counter, increments it on inc_i, and serves CSR reads and writes of the LO and HI halves
//  over a req/ack handshake. A LO read snapshots HI so that a LO-then-HI read pair is coherent.
//  Sits in the CSR unit between the CSR address decode and the pipeline event sources.
// PARAMETERS
//  CSR_XLEN  32       CSR bus width; the counter is 2*CSR_XLEN bits.
//  ADDR_LO   12'hB00  CSR address of the low half.
//  ADDR_HI   12'hB80  CSR address of the high half.
// PORTS
//  clk      in   1           Clock; all state updates on posedge.
//  rst      in   1           Reset; asynchronous, active-high.
//  inc_i    in   1           Increment request, sampled each posedge.
//  req_i    in   1           CSR access request; held high until ack_o.
//  we_i     in   1           1 = write, 0 = read; valid with req_i.
//  addr_i   in   12          CSR address; valid with req_i.
//  wdata_i  in   CSR_XLEN    Write data; valid with req_i.
//  ack_o    out  1           One-cycle completion strobe.
//  err_o    out  1           Address miss; valid only with ack_o.
//  rdata_o  out  CSR_XLEN    Read data; valid only with ack_o.
//  cnt_o    out  2*CSR_XLEN  Live counter value (registered).
// BEHAVIOUR
//  Reset (rst=1, any time): cnt=0, snap=0, snap_vld=0, state=IDLE, ack_o=0, err_o=0, rdata_o=0.
//   Any in-flight access is dropped without an ack.
//  FSM: IDLE --(req_i sampled 1)--> RESP --(always)--> IDLE.
//  Accept edge: the posedge in IDLE with req_i=1. On this edge the block:
//   - decodes addr_i: hit = (addr_i==ADDR_LO)|(addr_i==ADDR_HI).
//   - read LO: rdata_o <= cnt[L]; snap <= cnt[H]; snap_vld <= 1.
//   - read HI: rdata_o <= snap_vld ? snap : cnt[H]; snap_vld <= 0.
//   - write LO/HI: replaces that half with wdata_i; other half is held; inc_i is ignored on
//     this edge; snap_vld <= 0; rdata_o <= 0.
//   - miss: err_o <= 1; rdata_o <= 0; no state change except the FSM.
//  "cnt" is the value before this edge's update.
//  RESP cycle: ack_o=1 for exactly one cycle; err_o and rdata_o are valid. At the next edge
//   ack_o, err_o and rdata_o return to 0.
//  Handshake:
//   - req_i sampled in RESP is ignored (the requester drops it after ack).
//   - Max throughput is one access per 2 cycles.
//   - Latency is 1 cycle from accept to ack.
//  Counter:
//   - every edge with inc_i=1 and no write accept: cnt <= cnt + 1.
//   - wraps all-ones -> 0 with no flag.
//   - LO carry into HI happens in the same edge.
//  Priority: rst > CSR write > inc_i.
//   - A read accept does not block the increment; the read returns the pre-increment value.
//  cnt_o = cnt register (no extra latency).
// TESTING
//  1 Reset: assert rst mid-RESP -> ack_o,err_o,rdata_o,cnt_o = 0 immediately; no ack after release.
//  2 Count/wrap: write LO=FFFF_FFFF, HI=FFFF_FFFF, then inc_i=1 for 1 cycle -> cnt_o=0.
//     Then inc_i for 5 cycles -> cnt_o=5.
//  3 Coherent read: cnt=0000_0000_FFFF_FFFF, inc_i=1 continuously.
//     Read LO -> rdata=FFFF_FFFF; then read HI -> rdata=0 (snapshot) although cnt_o[63:32]=1.
//  4 Write vs inc: write LO=0000_0010 with inc_i=1 on the accept edge -> cnt_o[31:0]=0000_0010 next
//     cycle, 0000_0011 one edge later.
//  5 Miss: req_i, addr_i=12'h123, read -> ack_o=1, err_o=1, rdata_o=0 one cycle after accept.
//     Counter is unaffected.
//  6 Back-to-back: req_i held high for 4 cycles -> acks on cycles 2 and 4 only; HI read
//     without a prior LO read -> live cnt[H].

Source files
------------

// File: rtl/core_csr_unit_counter_port.sv
`default_nettype none
// ============================================================================
// Module   : core_csr_unit_counter_port
// Purpose  : CSR responder for one 64-bit event counter on a 32-bit CSR bus;
//            a LO read snapshots HI so a LO-then-HI read pair is coherent.
// Revision : 1.0 - initial release
// ============================================================================
module core_csr_unit_counter_port #(
    parameter int          CSR_XLEN = 32,
    parameter logic [11:0] ADDR_LO  = 12'hB00,
    parameter logic [11:0] ADDR_HI  = 12'hB80
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inc_i,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [11:0]           addr_i,
    input  logic [CSR_XLEN-1:0]   wdata_i,
    output logic                  ack_o,
    output logic                  err_o,
    output logic [CSR_XLEN-1:0]   rdata_o,
    output logic [2*CSR_XLEN-1:0] cnt_o
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [2*CSR_XLEN-1:0] r_cnt;
    logic [2*CSR_XLEN-1:0] w_cnt_next;
    logic [CSR_XLEN-1:0]   r_snap;
    logic                  r_snap_vld;
    logic                  r_ack;
    logic                  r_err;
    logic [CSR_XLEN-1:0]   r_rdata;
    logic [CSR_XLEN-1:0]   w_rdata_next;

    logic w_accept;
    logic w_hit_lo;
    logic w_hit_hi;
    logic w_wr_lo;
    logic w_wr_hi;
    logic w_rd_lo;
    logic w_rd_hi;

    assign w_accept = (r_state == ST_IDLE) && req_i;
    assign w_hit_lo = (addr_i == ADDR_LO);
    assign w_hit_hi = (addr_i == ADDR_HI);
    assign w_wr_lo  = w_accept &&  we_i && w_hit_lo;
    assign w_wr_hi  = w_accept &&  we_i && w_hit_hi;
    assign w_rd_lo  = w_accept && !we_i && w_hit_lo;
    assign w_rd_hi  = w_accept && !we_i && w_hit_hi;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (req_i) w_state_next = ST_RESP;
            ST_RESP: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // A CSR write takes precedence over the increment on the same edge.
    always_comb begin
        w_cnt_next = r_cnt;
        if (w_wr_lo)
            w_cnt_next = {r_cnt[2*CSR_XLEN-1:CSR_XLEN], wdata_i};
        else if (w_wr_hi)
            w_cnt_next = {wdata_i, r_cnt[CSR_XLEN-1:0]};
        else if (inc_i)
            w_cnt_next = r_cnt + 1'b1;
    end

    always_comb begin
        w_rdata_next = '0;
        if (w_rd_lo)
            w_rdata_next = r_cnt[CSR_XLEN-1:0];
        else if (w_rd_hi)
            w_rdata_next = r_snap_vld ? r_snap : r_cnt[2*CSR_XLEN-1:CSR_XLEN];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_snap     <= '0;
            r_snap_vld <= 1'b0;
            r_ack      <= 1'b0;
            r_err      <= 1'b0;
            r_rdata    <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_ack   <= w_accept;
            r_err   <= w_accept && !(w_hit_lo || w_hit_hi);
            r_rdata <= w_rdata_next;
            // Misses leave the snapshot untouched; any other hit except LO read invalidates it.
            if (w_rd_lo) begin
                r_snap     <= r_cnt[2*CSR_XLEN-1:CSR_XLEN];
                r_snap_vld <= 1'b1;
            end else if (w_rd_hi || w_wr_lo || w_wr_hi) begin
                r_snap_vld <= 1'b0;
            end
        end
    end

    assign ack_o   = r_ack;
    assign err_o   = r_err;
    assign rdata_o = r_rdata;
    assign cnt_o   = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_core_csr_unit_counter_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_core_csr_unit_counter_port
// Purpose  : Self-checking bench: vector table plus multi-cycle sequences,
//            responses matched against a queue of expected acks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_core_csr_unit_counter_port;

    localparam logic [11:0] C_LO = 12'hB00;
    localparam logic [11:0] C_HI = 12'hB80;

    logic        clk;
    logic        rst;
    logic        inc_i;
    logic        req_i;
    logic        we_i;
    logic [11:0] addr_i;
    logic [31:0] wdata_i;
    logic        ack_o;
    logic        err_o;
    logic [31:0] rdata_o;
    logic [63:0] cnt_o;

    core_csr_unit_counter_port #(
        .CSR_XLEN (32),
        .ADDR_LO  (C_LO),
        .ADDR_HI  (C_HI)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (inc_i),
        .req_i   (req_i),
        .we_i    (we_i),
        .addr_i  (addr_i),
        .wdata_i (wdata_i),
        .ack_o   (ack_o),
        .err_o   (err_o),
        .rdata_o (rdata_o),
        .cnt_o   (cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
    } sb_t;

    typedef struct {
        logic        we;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rdata;
        logic [63:0] cnt;
    } vec_t;

    sb_t  sb_q[$];
    vec_t vecs[12];
    int   checks    = 0;
    int   failures  = 0;
    int   ack_count = 0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endfunction

    // Response monitor: every ack must match the oldest outstanding expectation.
    always @(posedge clk) begin
        #1;
        if (ack_o === 1'b1) begin
            ack_count++;
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_ack actual=1 required=0 at %0t", $time);
            end else begin
                sb_t e;
                e = sb_q.pop_front();
                chk("ack_err", 64'(err_o), 64'(e.err));
                chk("ack_rdata", 64'(rdata_o), 64'(e.rdata));
            end
        end
    end

    // Caller is at a negedge; returns at a negedge after the access has completed.
    task automatic access(input logic we, input logic [11:0] addr, input logic [31:0] wdata,
                          input logic exp_err, input logic [31:0] exp_rdata);
        sb_t e;
        e.err   = exp_err;
        e.rdata = exp_rdata;
        sb_q.push_back(e);
        req_i   = 1'b1;
        we_i    = we;
        addr_i  = addr;
        wdata_i = wdata;
        @(posedge clk);
        @(negedge clk);
        req_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("ack_seen_outstanding", 64'(sb_q.size()), 64'd0);
        if (sb_q.size() != 0) sb_q.delete();
    endtask

    initial begin
        int acks_before;
        sb_t e;

        vecs[0]  = '{1'b1, C_LO,    32'h0000_0010, 1'b0, 32'h0,          64'h0000_0000_0000_0010};
        vecs[1]  = '{1'b1, C_HI,    32'hDEAD_BEEF, 1'b0, 32'h0,          64'hDEAD_BEEF_0000_0010};
        vecs[2]  = '{1'b0, C_HI,    32'h0,         1'b0, 32'hDEAD_BEEF,  64'hDEAD_BEEF_0000_0010};
        vecs[3]  = '{1'b0, C_LO,    32'h0,         1'b0, 32'h0000_0010,  64'hDEAD_BEEF_0000_0010};
        vecs[4]  = '{1'b1, C_HI,    32'h0000_0001, 1'b0, 32'h0,          64'h0000_0001_0000_0010};
        vecs[5]  = '{1'b0, C_HI,    32'h0,         1'b0, 32'h0000_0001,  64'h0000_0001_0000_0010};
        vecs[6]  = '{1'b0, C_LO,    32'h0,         1'b0, 32'h0000_0010,  64'h0000_0001_0000_0010};
        vecs[7]  = '{1'b0, 12'h123, 32'h0,         1'b1, 32'h0,          64'h0000_0001_0000_0010};
        vecs[8]  = '{1'b1, 12'h7FF, 32'hFFFF_FFFF, 1'b1, 32'h0,          64'h0000_0001_0000_0010};
        vecs[9]  = '{1'b0, C_HI,    32'h0,         1'b0, 32'h0000_0001,  64'h0000_0001_0000_0010};
        vecs[10] = '{1'b1, C_LO,    32'hCAFE_F00D, 1'b0, 32'h0,          64'h0000_0001_CAFE_F00D};
        vecs[11] = '{1'b0, C_LO,    32'h0,         1'b0, 32'hCAFE_F00D,  64'h0000_0001_CAFE_F00D};

        rst = 1'b1; inc_i = 1'b0; req_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0;
        repeat (2) @(negedge clk);
        chk("reset_ack", 64'(ack_o), 64'd0);
        chk("reset_err", 64'(err_o), 64'd0);
        chk("reset_rdata", 64'(rdata_o), 64'd0);
        chk("reset_cnt", cnt_o, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            access(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].err, vecs[i].rdata);
            chk($sformatf("vec%0d_cnt", i), cnt_o, vecs[i].cnt);
        end

        // Wrap from all-ones, then count up.
        access(1'b1, C_LO, 32'hFFFF_FFFF, 1'b0, 32'h0);
        access(1'b1, C_HI, 32'hFFFF_FFFF, 1'b0, 32'h0);
        chk("preset_all_ones", cnt_o, 64'hFFFF_FFFF_FFFF_FFFF);
        inc_i = 1'b1;
        @(negedge clk);
        inc_i = 1'b0;
        chk("wrap_to_zero", cnt_o, 64'd0);
        inc_i = 1'b1;
        repeat (5) @(negedge clk);
        inc_i = 1'b0;
        chk("count_five", cnt_o, 64'd5);

        // Coherent LO/HI read while counting across the LO carry.
        access(1'b1, C_LO, 32'hFFFF_FFFF, 1'b0, 32'h0);
        access(1'b1, C_HI, 32'h0,         1'b0, 32'h0);
        inc_i = 1'b1;
        access(1'b0, C_LO, 32'h0, 1'b0, 32'hFFFF_FFFF);
        access(1'b0, C_HI, 32'h0, 1'b0, 32'h0);
        chk("coherent_live_hi", 64'(cnt_o[63:32]), 64'd1);
        inc_i = 1'b0;
        chk("coherent_cnt", cnt_o, 64'h0000_0001_0000_0003);

        // Write beats increment on the accept edge; increment resumes next edge.
        access(1'b1, C_HI, 32'h0, 1'b0, 32'h0);
        e.err = 1'b0; e.rdata = 32'h0;
        sb_q.push_back(e);
        inc_i = 1'b1; req_i = 1'b1; we_i = 1'b1; addr_i = C_LO; wdata_i = 32'h0000_0010;
        @(posedge clk); #2;
        chk("write_beats_inc", 64'(cnt_o[31:0]), 64'h10);
        @(negedge clk);
        req_i = 1'b0;
        @(posedge clk); #2;
        chk("inc_after_write", 64'(cnt_o[31:0]), 64'h11);
        @(negedge clk);
        inc_i = 1'b0;
        chk("wr_inc_outstanding", 64'(sb_q.size()), 64'd0);

        // Request held for four edges: acks after edges 1 and 3 only, live HI.
        access(1'b1, C_HI, 32'h0000_ABCD, 1'b0, 32'h0);
        e.err = 1'b0; e.rdata = 32'h0000_ABCD;
        sb_q.push_back(e);
        sb_q.push_back(e);
        acks_before = ack_count;
        req_i = 1'b1; we_i = 1'b0; addr_i = C_HI;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #2;
            chk($sformatf("b2b_ack_edge%0d", i + 1), 64'(ack_o), (i % 2 == 0) ? 64'd1 : 64'd0);
        end
        @(negedge clk);
        req_i = 1'b0;
        repeat (2) @(negedge clk);
        chk("b2b_ack_count", 64'(ack_count - acks_before), 64'd2);
        chk("b2b_outstanding", 64'(sb_q.size()), 64'd0);

        // Reset during the response cycle clears everything at once.
        chk("pre_reset_cnt", cnt_o, 64'h0000_ABCD_0000_0011);
        e.err = 1'b0; e.rdata = 32'h0000_0011;
        sb_q.push_back(e);
        req_i = 1'b1; we_i = 1'b0; addr_i = C_LO;
        @(posedge clk); #2;
        chk("pre_reset_ack", 64'(ack_o), 64'd1);
        rst = 1'b1;
        #1;
        chk("midresp_ack", 64'(ack_o), 64'd0);
        chk("midresp_err", 64'(err_o), 64'd0);
        chk("midresp_rdata", 64'(rdata_o), 64'd0);
        chk("midresp_cnt", cnt_o, 64'd0);
        @(negedge clk);
        req_i = 1'b0;
        acks_before = ack_count;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("no_ack_after_reset", 64'(ack_count - acks_before), 64'd0);
        chk("post_reset_cnt", cnt_o, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
